// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and field helpers for the fetch/pipeline controller.
// Feature macro: PIPELINE_CTRL_LOAD_STALL_EN enables the load-use interlock.
package pipeline_ctrl_pkg;

   localparam int unsigned INST_W  = 32;
   localparam int unsigned OPC_W   = 7;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned RD_LSB  = 7;
   localparam int unsigned RS1_LSB = 15;
   localparam int unsigned RS2_LSB = 20;

   // addi x0,x0,0 -- the canonical bubble instruction
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [OPC_W-1:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111
   } opcode_e;

   function automatic logic [OPC_W-1:0] opcode_of(input logic [INST_W-1:0] inst);
      return inst[OPC_W-1:0];
   endfunction

   function automatic logic [REG_W-1:0] rd_of(input logic [INST_W-1:0] inst);
      return inst[RD_LSB +: REG_W];
   endfunction

   function automatic logic [REG_W-1:0] rs1_of(input logic [INST_W-1:0] inst);
      return inst[RS1_LSB +: REG_W];
   endfunction

   function automatic logic [REG_W-1:0] rs2_of(input logic [INST_W-1:0] inst);
      return inst[RS2_LSB +: REG_W];
   endfunction

   // I, R, S and B formats read rs1
   function automatic logic uses_rs1(input logic [INST_W-1:0] inst);
      case (opcode_of(inst))
         OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // only R, S and B formats read rs2
   function automatic logic uses_rs2(input logic [INST_W-1:0] inst);
      case (opcode_of(inst))
         OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: instruction, PC and valid with hold/bubble control.
module pipe_stage_reg
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              bubble,
   input  logic [INST_W-1:0] d_inst,
   input  logic [XLEN-1:0]   d_pc,
   input  logic              d_valid,
   output logic [INST_W-1:0] q_inst,
   output logic [XLEN-1:0]   q_pc,
   output logic              q_valid
);

   // hold wins over bubble; a bubble keeps the source PC for traceability
   always_ff @(posedge clk) begin
      if (rst) begin
         q_inst  <= NOP_INST;
         q_pc    <= '0;
         q_valid <= 1'b0;
      end else if (hold) begin
         q_inst  <= q_inst;
         q_pc    <= q_pc;
         q_valid <= q_valid;
      end else if (bubble) begin
         q_inst  <= NOP_INST;
         q_pc    <= d_pc;
         q_valid <= 1'b0;
      end else begin
         q_inst  <= d_inst;
         q_pc    <= d_pc;
         q_valid <= d_valid;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// In-order fetch PC and pipeline-register controller with redirect squash.
// Optional macro PIPELINE_CTRL_LOAD_STALL_EN adds the load-use interlock;
// without it stall is tied low and software fills load delay slots.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned    XLEN     = 32,
   parameter int unsigned    NSTAGES  = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [INST_W-1:0]         imem_rdata,
   input  logic                      imem_valid,
   output logic                      imem_req,
   output logic [XLEN-1:0]           pc,
   input  logic                      redirect,
   input  logic [XLEN-1:0]           redirect_pc,
   output logic [INST_W*NSTAGES-1:0] inst_pipe,
   output logic [XLEN*NSTAGES-1:0]   pc_pipe,
   output logic [NSTAGES-1:0]        valid_pipe,
   output logic                      stall,
   output logic                      flush
);

   logic [INST_W-1:0]  st_inst  [NSTAGES];
   logic [XLEN-1:0]    st_pc    [NSTAGES];
   logic [NSTAGES-1:0] st_valid;

   logic [INST_W-1:0]  d_inst   [NSTAGES];
   logic [XLEN-1:0]    d_pc     [NSTAGES];
   logic [NSTAGES-1:0] d_valid;
   logic [NSTAGES-1:0] hold_v;
   logic [NSTAGES-1:0] bubble_v;

   assign imem_req = ~rst;
   assign flush    = redirect & ~rst;

`ifdef PIPELINE_CTRL_LOAD_STALL_EN
   logic hazard_c;

   // EX holds a valid load whose destination is read by the valid ID instruction
   always_comb begin
      logic             ex_load;
      logic [REG_W-1:0] ex_rd;
      ex_rd    = rd_of(st_inst[1]);
      ex_load  = st_valid[1] && (opcode_of(st_inst[1]) == OPC_LOAD) && (ex_rd != '0);
      hazard_c = ex_load && st_valid[0] &&
                 ((uses_rs1(st_inst[0]) && (rs1_of(st_inst[0]) == ex_rd)) ||
                  (uses_rs2(st_inst[0]) && (rs2_of(st_inst[0]) == ex_rd)));
   end

   assign stall = hazard_c & ~redirect & ~rst;
`else
   assign stall = 1'b0;
`endif

   // stage inputs and per-stage hold/bubble controls
   always_comb begin
      for (int k = 0; k < int'(NSTAGES); k++) begin
         d_inst[k] = NOP_INST;
         d_pc[k]   = '0;
      end
      d_valid  = '0;
      hold_v   = '0;
      bubble_v = '0;

      d_inst[0]  = imem_rdata;
      d_pc[0]    = pc;
      d_valid[0] = 1'b1;
      for (int k = 1; k < int'(NSTAGES); k++) begin
         d_inst[k]  = st_inst[k-1];
         d_pc[k]    = st_pc[k-1];
         d_valid[k] = st_valid[k-1];
      end

      hold_v[0]   = stall;
      bubble_v[0] = redirect | ~imem_valid;
      bubble_v[1] = stall | redirect;
   end

   // fetch PC: redirect beats stall beats accept; target is word aligned
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= redirect_pc & ~XLEN'(3);
      end else if (!stall && imem_valid) begin
         pc <= pc + XLEN'(4);
      end
   end

   // one register per stage, packed onto the flat output buses
   for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
      pipe_stage_reg #(.XLEN(XLEN)) u_stage (
         .clk     (clk),
         .rst     (rst),
         .hold    (hold_v[k]),
         .bubble  (bubble_v[k]),
         .d_inst  (d_inst[k]),
         .d_pc    (d_pc[k]),
         .d_valid (d_valid[k]),
         .q_inst  (st_inst[k]),
         .q_pc    (st_pc[k]),
         .q_valid (st_valid[k])
      );
      assign inst_pipe[INST_W*k +: INST_W] = st_inst[k];
      assign pc_pipe[XLEN*k +: XLEN]       = st_pc[k];
   end

   assign valid_pipe = st_valid;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC/address width, 32..64.
REQ-002 SHALL have parameter NSTAGES, default 4: post-fetch pipeline register stages, 2..8; stage 0 = ID, stage 1 = EX, stage NSTAGES-1 = WB.
REQ-003 SHALL have parameter RESET_PC, default 0: fetch PC after reset.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge; all state on this clock.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port imem_rdata, input, 32: instruction fetched at pc.
REQ-007 SHALL have port imem_valid, input, 1: imem_rdata valid this cycle.
REQ-008 SHALL have port imem_req, output, 1: fetch request for pc.
REQ-009 SHALL have port pc, output, XLEN: current fetch PC.
REQ-010 SHALL have port redirect, input, 1: EX-stage control transfer taken.
REQ-011 SHALL have port redirect_pc, input, XLEN: redirect target.
REQ-012 SHALL have port inst_pipe, output, 32*NSTAGES: per-stage instruction, stage k at bits [32k+31:32k].
REQ-013 SHALL have port pc_pipe, output, XLEN*NSTAGES: per-stage PC, same packing.
REQ-014 SHALL have port valid_pipe, output, NSTAGES: per-stage valid bit.
REQ-015 SHALL have port stall, output, 1: load-use interlock active this cycle.
REQ-016 SHALL have port flush, output, 1: redirect squash active this cycle.

Function
REQ-017 SHALL drive imem_req high whenever rst is low.
REQ-018 SHALL, on fetch accept (imem_valid & ~stall & ~redirect), load stage 0 with {imem_rdata, pc, valid=1} and set pc <= pc+4 modulo 2^XLEN.
REQ-019 SHALL, with imem_valid low and no stall/redirect, load a bubble into stage 0 and hold pc.
REQ-020 SHALL define bubble as inst=32'h00000013 (NOP), valid=0, PC of the source stage retained.
REQ-021 SHALL, for k>=2, shift stage k-1 into stage k every cycle unconditionally.
REQ-022 SHALL assert stall combinationally when stage 1 is a valid LOAD (opcode 7'b0000011) with rd!=0 and stage 0 is valid with rs1==rd (formats using rs1) or rs2==rd (R, S, B formats).
REQ-023 SHALL, during stall, hold pc and stage 0 and load a bubble into stage 1; stall lasts exactly one cycle per hazard.
REQ-024 SHALL, on redirect, set pc <= redirect_pc, load bubbles into stages 0 and 1, and assert flush that cycle; stage 1 (the branch) advances normally to stage 2.
REQ-025 SHALL give redirect priority over stall; stall SHALL be forced low while redirect is high.
REQ-026 SHALL ignore redirect_pc[1:0] and redirect when redirect is low.
REQ-027 SHALL present all outputs except stall, flush, imem_req directly from registers (zero combinational input-to-output path).

Reset
REQ-028 SHALL, on rst high at a clock edge, set pc=RESET_PC, all inst stages=NOP, all valid=0, all stage PCs=0.
REQ-029 SHALL, while rst high, hold stall=0, flush=0, imem_req=0, overriding redirect and imem_valid mid-operation.

Configuration
REQ-030 SHALL, with PIPELINE_CTRL_LOAD_STALL_EN defined, implement REQ-022/023.
REQ-031 SHALL, without PIPELINE_CTRL_LOAD_STALL_EN, tie stall to 0 and omit hazard logic; software schedules load delay slots.

Structure
REQ-032 SHALL take opcode constants, NOP encoding and rd/rs1/rs2 field positions from shared package pipeline_ctrl_pkg.
REQ-033 SHALL build each stage from one sub-module, pipe_stage_reg (inst, pc, valid; with hold and bubble controls), instantiated NSTAGES times by generate.

Verification
REQ-034 SHALL check reset: after rst, pc=RESET_PC, valid_pipe=0, all inst=0x00000013; first fetch with imem_valid=1 -> pc=RESET_PC+4, stage 0 valid next cycle.
REQ-035 SHALL check streaming: 5 back-to-back valid fetches -> each word reaches stage NSTAGES-1 exactly NSTAGES cycles after acceptance with its own PC.
REQ-036 SHALL check load-use: lw x5,0(x1) then add x6,x5,x2 -> stall=1 one cycle, pc held, one bubble in stage 1; lw x0 or independent add -> no stall.
REQ-037 SHALL check redirect: redirect=1, redirect_pc=0x100 -> flush=1, stages 0-1 bubbles next cycle, pc=0x100; simultaneous load-use hazard -> stall=0.
REQ-038 SHALL check fetch gaps and wrap: imem_valid=0 for 3 cycles -> 3 bubbles, pc held; pc=0xFFFFFFFC with XLEN=32 accepting -> pc=0x00000000.
REQ-039 SHALL check rst asserted mid-stream with redirect high -> full reset state next cycle, redirect ignored.
